// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one main-memory port between the I-cache and D-cache.
// Serialises fills and store-through writes; a watchdog ends reads whose response never arrives.
module memory_arbiter #(
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned FILL_DATA_WIDTH  = 128,
  parameter int unsigned EVICT_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT          = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        icache_req,
  input  logic                        icache_store,
  input  logic                        icache_store_word,
  input  logic [ADDRESS_WIDTH-1:0]    icache_address,
  input  logic [EVICT_DATA_WIDTH-1:0] icache_evict_data,
  output logic                        icache_ack,
  input  logic                        dcache_req,
  input  logic                        dcache_store,
  input  logic                        dcache_store_word,
  input  logic [ADDRESS_WIDTH-1:0]    dcache_address,
  input  logic [EVICT_DATA_WIDTH-1:0] dcache_evict_data,
  output logic                        dcache_ack,
  output logic [FILL_DATA_WIDTH-1:0]  fill_data,
  output logic                        mem_req,
  output logic                        mem_store,
  output logic                        mem_store_word,
  output logic [ADDRESS_WIDTH-1:0]    mem_address,
  output logic [EVICT_DATA_WIDTH-1:0] mem_evict_data,
  input  logic [FILL_DATA_WIDTH-1:0]  mem_fill_data,
  input  logic                        mem_response_valid,
  output logic                        busy,
  output logic                        timeout_error
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // r_grant_d / r_prio_d: 1 selects the D port, 0 the I port
  logic [1:0]      r_state;
  logic            r_grant_d;
  logic            r_prio_d;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout_error;

  logic [1:0]      w_state_nxt;
  logic            w_grant_nxt;
  logic            w_prio_nxt;
  logic [WD_W-1:0] w_wd_nxt;
  logic            w_timeout_nxt;
  logic            w_ack;
  logic            w_issue;

  logic                        w_sel_store;
  logic                        w_sel_store_word;
  logic [ADDRESS_WIDTH-1:0]    w_sel_address;
  logic [EVICT_DATA_WIDTH-1:0] w_sel_evict_data;

  // Command fields of the granted port
  always_comb begin
    w_sel_store      = r_grant_d ? dcache_store      : icache_store;
    w_sel_store_word = r_grant_d ? dcache_store_word : icache_store_word;
    w_sel_address    = r_grant_d ? dcache_address    : icache_address;
    w_sel_evict_data = r_grant_d ? dcache_evict_data : icache_evict_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_grant_d       <= 1'b0;
      r_prio_d        <= 1'b1;
      r_wd            <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_grant_d       <= w_grant_nxt;
      r_prio_d        <= w_prio_nxt;
      r_wd            <= w_wd_nxt;
      r_timeout_error <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant_d;
    w_prio_nxt    = r_prio_d;
    w_wd_nxt      = r_wd;
    w_timeout_nxt = r_timeout_error;
    w_ack         = 1'b0;
    w_issue       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (icache_req || dcache_req) begin
          w_grant_nxt = dcache_req && (!icache_req || r_prio_d);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (w_sel_store) begin
          w_ack       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd_nxt    = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_response_valid) begin
          w_ack       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wd >= WD_W'(TIMEOUT - 1)) begin
          w_ack         = 1'b1;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Round-robin: the port just served loses the next tie
    if (w_ack) begin
      w_prio_nxt = !r_grant_d;
    end
  end

  assign icache_ack     = w_ack && !r_grant_d;
  assign dcache_ack     = w_ack && r_grant_d;
  assign mem_req        = w_issue;
  assign mem_store      = w_issue && w_sel_store;
  assign mem_store_word = w_issue && w_sel_store_word;
  assign mem_address    = w_issue ? w_sel_address : '0;
  assign mem_evict_data = w_issue ? w_sel_evict_data : '0;
  assign fill_data      = mem_fill_data;
  assign busy           = (r_state != S_IDLE);
  assign timeout_error  = r_timeout_error;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 16-line memory model (5-cycle read latency).
module tb_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned FW = 128;
  localparam int unsigned EW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_req, icache_store, icache_store_word;
  logic [AW-1:0] icache_address;
  logic [EW-1:0] icache_evict_data;
  logic          icache_ack;
  logic          dcache_req, dcache_store, dcache_store_word;
  logic [AW-1:0] dcache_address;
  logic [EW-1:0] dcache_evict_data;
  logic          dcache_ack;
  logic [FW-1:0] fill_data;
  logic          mem_req, mem_store, mem_store_word;
  logic [AW-1:0] mem_address;
  logic [EW-1:0] mem_evict_data;
  logic [FW-1:0] mem_fill_data;
  logic          mem_response_valid;
  logic          busy, timeout_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDRESS_WIDTH(AW), .FILL_DATA_WIDTH(FW), .EVICT_DATA_WIDTH(EW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .icache_req(icache_req), .icache_store(icache_store),
    .icache_store_word(icache_store_word), .icache_address(icache_address),
    .icache_evict_data(icache_evict_data), .icache_ack(icache_ack),
    .dcache_req(dcache_req), .dcache_store(dcache_store),
    .dcache_store_word(dcache_store_word), .dcache_address(dcache_address),
    .dcache_evict_data(dcache_evict_data), .dcache_ack(dcache_ack),
    .fill_data(fill_data),
    .mem_req(mem_req), .mem_store(mem_store), .mem_store_word(mem_store_word),
    .mem_address(mem_address), .mem_evict_data(mem_evict_data),
    .mem_fill_data(mem_fill_data), .mem_response_valid(mem_response_valid),
    .busy(busy), .timeout_error(timeout_error)
  );

  // Memory model: line i preloaded with {4{32'h1000_0000 + i}}
  logic [FW-1:0] mem [16];
  logic [FW-1:0] r_line = '0;
  int            lat = 0;
  bit            r_loaded = 1'b0;
  logic          mute = 1'b0;

  always @(posedge clk) begin
    if (!r_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= {4{32'(32'h1000_0000 + i)}};
      r_loaded <= 1'b1;
    end else if (mem_req && mem_store) begin
      if (mem_store_word)
        mem[mem_address[7:4]][{mem_address[3:2], 5'b0} +: 32] <= mem_evict_data;
      else
        mem[mem_address[7:4]][{mem_address[3:0], 3'b0} +: 8] <= mem_evict_data[7:0];
    end
    if (mem_req && !mem_store) begin
      r_line <= mem[mem_address[7:4]];
      lat    <= 5;
    end else if (lat > 0) begin
      lat <= lat - 1;
    end
  end

  assign mem_response_valid = (lat == 1) && !mute;
  assign mem_fill_data      = r_line;

  // Requests must stay up until their ack
  logic p_ireq = 1'b0, p_iack = 1'b0, p_dreq = 1'b0, p_dack = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      p_ireq <= 1'b0; p_iack <= 1'b0; p_dreq <= 1'b0; p_dack <= 1'b0;
    end else begin
      if (p_ireq && !p_iack && !icache_req) begin
        failures++;
        $error("FAIL icache_req_dropped observed=0 expected=1");
      end
      if (p_dreq && !p_dack && !dcache_req) begin
        failures++;
        $error("FAIL dcache_req_dropped observed=0 expected=1");
      end
      p_ireq <= icache_req; p_iack <= icache_ack;
      p_dreq <= dcache_req; p_dack <= dcache_ack;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on one port; lat = cycles from req to ack (-1 if none)
  task automatic txn(input bit is_d, input bit st, input bit wd,
                     input logic [31:0] addr, input logic [31:0] data,
                     output int ack_lat, output logic [127:0] fd, output int nreq,
                     output logic [31:0] maddr, output logic mst, output logic mwd,
                     output logic [31:0] mdat);
    step();
    if (is_d) begin
      dcache_store = st; dcache_store_word = wd; dcache_address = addr;
      dcache_evict_data = data; dcache_req = 1'b1;
    end else begin
      icache_store = st; icache_store_word = wd; icache_address = addr;
      icache_evict_data = data; icache_req = 1'b1;
    end
    ack_lat = -1; fd = '0; nreq = 0; maddr = '0; mst = 1'b0; mwd = 1'b0; mdat = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++; maddr = mem_address; mst = mem_store; mwd = mem_store_word; mdat = mem_evict_data;
      end
      if (is_d ? dcache_ack : icache_ack) begin
        ack_lat = n;
        fd = fill_data;
        break;
      end
      step();
    end
    step();
    if (is_d) dcache_req = 1'b0; else icache_req = 1'b0;
  endtask

  int            t_lat, t_nreq, k;
  logic [127:0]  t_fd;
  logic [31:0]   t_addr, t_dat;
  logic          t_st, t_wd, both, seen, drop_i;
  logic          order [5];

  initial begin
    reset = 1'b0;
    icache_req = 0; icache_store = 0; icache_store_word = 0; icache_address = '0; icache_evict_data = '0;
    dcache_req = 0; dcache_store = 0; dcache_store_word = 0; dcache_address = '0; dcache_evict_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_iack", 128'(icache_ack), 128'(0));
    chk("rst_dack", 128'(dcache_ack), 128'(0));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_timeout", 128'(timeout_error), 128'(0));
    step();
    reset = 1'b1;

    // D read of line 0x40
    txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, t_lat, t_fd, t_nreq, t_addr, t_st, t_wd, t_dat);
    chk("dread_lat", 128'(t_lat), 128'(6));
    chk("dread_nreq", 128'(t_nreq), 128'(1));
    chk("dread_addr", 128'(t_addr), 128'(32'h40));
    chk("dread_store", 128'(t_st), 128'(0));
    chk("dread_fill", t_fd, 128'h10000004_10000004_10000004_10000004);

    // D word store then I read of the same line
    txn(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, t_lat, t_fd, t_nreq, t_addr, t_st, t_wd, t_dat);
    chk("wstore_lat", 128'(t_lat), 128'(1));
    chk("wstore_store", 128'(t_st), 128'(1));
    chk("wstore_word", 128'(t_wd), 128'(1));
    chk("wstore_data", 128'(t_dat), 128'(32'hDEADBEEF));
    txn(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, t_lat, t_fd, t_nreq, t_addr, t_st, t_wd, t_dat);
    chk("iread_lat", 128'(t_lat), 128'(6));
    chk("iread_fill", t_fd, 128'h10000001_10000001_10000001_DEADBEEF);

    // Byte store 0xA5 at 0x13 then read back
    txn(1'b1, 1'b1, 1'b0, 32'h13, 32'h000000A5, t_lat, t_fd, t_nreq, t_addr, t_st, t_wd, t_dat);
    chk("bstore_lat", 128'(t_lat), 128'(1));
    chk("bstore_word", 128'(t_wd), 128'(0));
    chk("bstore_byte", 128'(t_dat[7:0]), 128'(8'hA5));
    chk("bstore_addr", 128'(t_addr), 128'(32'h13));
    txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, t_lat, t_fd, t_nreq, t_addr, t_st, t_wd, t_dat);
    chk("bread_fill", t_fd, 128'h10000001_10000001_10000001_A5ADBEEF);

    // Reset mid-WAIT, then a stray response must be ignored
    step();
    dcache_store = 0; dcache_address = 32'h40; dcache_req = 1'b1;
    repeat (3) step();
    chk("mid_wait_busy", 128'(busy), 128'(1));
    reset = 1'b0;
    #1;
    chk("rstw_busy", 128'(busy), 128'(0));
    chk("rstw_dack", 128'(dcache_ack), 128'(0));
    chk("rstw_mem_req", 128'(mem_req), 128'(0));
    dcache_req = 1'b0;
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mem_response_valid) seen = 1'b1;
      chk("stray_ack", 128'({icache_ack, dcache_ack}), 128'(0));
      chk("stray_busy", 128'(busy), 128'(0));
      step();
    end
    chk("stray_seen", 128'(seen), 128'(1));

    // Both ports requesting from reset: D, I, D, I, D
    reset = 1'b0;
    icache_store = 1; icache_store_word = 1; icache_address = 32'h20; icache_evict_data = 32'h11111111;
    dcache_store = 1; dcache_store_word = 1; dcache_address = 32'h24; dcache_evict_data = 32'h22222222;
    icache_req = 1'b1; dcache_req = 1'b1;
    step();
    reset = 1'b1;
    k = 0; both = 1'b0; drop_i = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (icache_ack && dcache_ack) both = 1'b1;
      if (icache_ack || dcache_ack) begin
        order[k] = dcache_ack;
        k++;
        if (k == 4) drop_i = 1'b1;
      end
      step();
      if (drop_i) icache_req = 1'b0;
      if (k == 5) break;
    end
    dcache_req = 1'b0;
    chk("rr_count", 128'(k), 128'(5));
    chk("rr_both", 128'(both), 128'(0));
    chk("rr_0_is_d", 128'(order[0]), 128'(1));
    chk("rr_1_is_d", 128'(order[1]), 128'(0));
    chk("rr_2_is_d", 128'(order[2]), 128'(1));
    chk("rr_3_is_d", 128'(order[3]), 128'(0));
    chk("rr_4_is_d", 128'(order[4]), 128'(1));

    // Watchdog: no response, ack 16 cycles after ISSUE
    mute = 1'b1;
    txn(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, t_lat, t_fd, t_nreq, t_addr, t_st, t_wd, t_dat);
    chk("to_lat", 128'(t_lat), 128'(17));
    @(negedge clk);
    chk("to_flag", 128'(timeout_error), 128'(1));
    chk("to_busy", 128'(busy), 128'(0));
    repeat (5) step();
    @(negedge clk);
    chk("to_sticky", 128'(timeout_error), 128'(1));
    step();
    reset = 1'b0;
    #1;
    chk("to_cleared", 128'(timeout_error), 128'(0));
    step();
    reset = 1'b1;
    mute = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares the single main-memory model between the instruction cache (port I) and the data cache (port D). It serialises cache fill reads and store-through writes, drives exactly one memory transaction at a time, and waits out the memory's fixed transfer latency before returning fill data. A watchdog counter flags a read whose response never arrives.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, address width on both ports and memory side
- FILL_DATA_WIDTH, 128, width of one fill line returned by memory
- EVICT_DATA_WIDTH, 32, store data width (one word; byte stores use bits [7:0])
- TIMEOUT, 16, max cycles spent waiting for a read response; must be > memory DATA_TRANSFER_TIME

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- icache_req / dcache_req  in  1  request; held stable with its fields until the matching ack
- icache_store / dcache_store  in  1  1 = write, 0 = line fill read
- icache_store_word / dcache_store_word  in  1  1 = word store, 0 = byte store
- icache_address / dcache_address  in  ADDRESS_WIDTH  byte address
- icache_evict_data / dcache_evict_data  in  EVICT_DATA_WIDTH  store data
- icache_ack / dcache_ack  out  1  one-cycle completion pulse
- fill_data  out  FILL_DATA_WIDTH  memory fill data, valid when an ack is high for a read
- mem_req, mem_store, mem_store_word  out  1  memory command
- mem_address  out  ADDRESS_WIDTH; mem_evict_data  out  EVICT_DATA_WIDTH
- mem_fill_data  in  FILL_DATA_WIDTH; mem_response_valid  in  1
- busy  out  1  state != IDLE
- timeout_error  out  1  sticky, set on watchdog expiry

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req high, latch grant (I or D) and go ISSUE. If both high, winner = port pointed to by round-robin pointer `prio`. No req: stay.
- ISSUE (exactly one cycle): mem_req=1; mem_store, mem_store_word, mem_address, mem_evict_data muxed from granted port. Store: granted ack=1 this cycle, go IDLE. Read: clear watchdog, go WAIT.
- WAIT: mem_req=0. On mem_response_valid: granted ack=1, go IDLE. Else watchdog increments; when it reaches TIMEOUT-1 without response: set timeout_error, pulse granted ack (fill_data don't-care), go IDLE.
- prio flips to the non-granted port on every completed transaction (ack). Reset value: prio = D.
- fill_data = mem_fill_data always (pass-through); consumers qualify with ack.
- Outside ISSUE all mem_* command outputs are 0.
- mem_response_valid in IDLE or ISSUE (stray response, e.g. after reset) is ignored.
- Watchdog width $clog2(TIMEOUT+1); saturates, never wraps.

## Timing
- Reset values: state IDLE, prio D, grant cleared, watchdog 0, timeout_error 0; all acks, mem_* outputs, busy = 0.
- Reset asserted mid-transaction: immediate return to IDLE, no ack emitted; in-flight memory response later ignored.
- Store: req seen in cycle t -> ISSUE at t+1, ack at t+1, memory write at t+1 edge; next grant earliest at t+2 (IDLE at t+2, ISSUE t+3).
- Read: req at t -> ISSUE t+1 -> response and ack at t+1+DATA_TRANSFER_TIME (t+6 for default memory).
- At most one ack high per cycle; ack never asserted in IDLE.
- Requester dropping req before ack is illegal; behaviour undefined (bench asserts against it).
- A new request on the just-served port in the cycle after its ack competes normally under prio.

## Test plan
- Reset: reset low mid-WAIT -> busy=0, acks=0, mem_req=0 immediately; stray mem_response_valid 3 cycles later produces no ack.
- D read alone, address 0x40, memory latency 5 -> mem_req one cycle with mem_address 0x40, mem_store 0; dcache_ack exactly 6 cycles after dcache_req, fill_data equals memory line 0x40.
- D word store 0xDEADBEEF at 0x10, then I read 0x10 -> dcache_ack in ISSUE cycle; I read returns line with word0 = 0xDEADBEEF.
- Both req high from reset, each re-requesting continuously -> grant order D, I, D, I; no port served twice consecutively.
- Byte store (store_word=0) of 0xA5 at 0x13 -> mem_store_word 0, mem_evict_data[7:0]=0xA5; subsequent read shows byte 3 = 0xA5 only.
- Memory stub never raises response_valid, TIMEOUT=16 -> icache_ack pulses 16 cycles after ISSUE, timeout_error goes 1 and stays 1 until reset.
